// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default widths.
package seq_divider_pkg;

    // Default operand widths, shared with the 4x4 multiplier bench.
    localparam int unsigned DefDividendW = 8;
    localparam int unsigned DefDivisorW  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Width of an iteration counter that must hold values 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor
// with a full-adder ripple and keep the difference only when it did not borrow.
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned DIVISOR_W = DefDivisorW
) (
    input  logic [DIVISOR_W-1:0] pr,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] pr_next,
    output logic                 q_bit
);

    // The trial value is one bit wider than the divisor so the bit shifted out of the
    // partial remainder takes part in the compare.
    localparam int unsigned TrialW = DIVISOR_W + 1;

    logic [TrialW-1:0]    trial;
    logic [TrialW-1:0]    sub_b;
    logic [TrialW:0]      carry;
    logic [DIVISOR_W-1:0] diff;

    assign trial    = {pr, bit_in};
    assign sub_b    = ~{1'b0, divisor};
    assign carry[0] = 1'b1;

    // Full-adder ripple computing trial + ~divisor + 1; the top difference bit is always 0
    // when no borrow occurs, so only its carry is formed.
    for (genvar i = 0; i < TrialW; i++) begin : g_ripple
        assign carry[i+1] = (trial[i] & sub_b[i]) | (carry[i] & (trial[i] ^ sub_b[i]));
        if (i < DIVISOR_W) begin : g_sum
            assign diff[i] = trial[i] ^ sub_b[i] ^ carry[i];
        end
    end

    // Carry-out set means no borrow, i.e. trial >= divisor.
    assign q_bit   = carry[TrialW];
    assign pr_next = q_bit ? diff : trial[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider with start/busy/done handshake; one quotient bit
// per clock, MSB first.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DefDividendW,
    parameter int unsigned DIVISOR_W  = DefDivisorW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] data_A,
    input  logic [DIVISOR_W-1:0]  data_B,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    localparam int unsigned CntW = cnt_width(DIVIDEND_W);

    div_state_e            state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]  pr_q, pr_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W-1:0]  step_pr;
    logic                  step_q;

    seq_divider_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr      (pr_q),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dsr_q),
        .pr_next (step_pr),
        .q_bit   (step_q)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            pr_q    <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            pr_q    <= pr_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath update: accept in IDLE/DONE, iterate in RUN.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        pr_d    = pr_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (data_B != '0) begin
                        state_d = StRun;
                        dvd_d   = data_A;
                        pr_d    = '0;
                        dsr_d   = data_B;
                        cnt_d   = CntW'(DIVIDEND_W - 1);
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                pr_d  = step_pr;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    quo_d   = {dvd_q[DIVIDEND_W-2:0], step_q};
                    rem_d   = step_pr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign div_by_zero = dbz_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;

endmodule
